// File: rtl/time_set_pkg.sv
// rtl/time_set_pkg.sv - shared types, constants and field arithmetic for time_set_ctrl
package time_set_pkg;

    localparam int HOURS_W     = 5;
    localparam int MINUTES_W   = 6;
    localparam int HOURS_MOD   = 24;
    localparam int MINUTES_MOD = 60;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SET_H  = 2'd1,
        ST_SET_M  = 2'd2,
        ST_COMMIT = 2'd3
    } edit_state_e;

    // Out-of-range live hours (corrupted chain, power-up garbage) restart at 0
    function automatic logic [HOURS_W-1:0] clamp_hours(input logic [HOURS_W-1:0] h);
        return (h >= HOURS_W'(HOURS_MOD)) ? '0 : h;
    endfunction

    function automatic logic [MINUTES_W-1:0] clamp_minutes(input logic [MINUTES_W-1:0] m);
        return (m >= MINUTES_W'(MINUTES_MOD)) ? '0 : m;
    endfunction

    function automatic logic [HOURS_W-1:0] inc_hours(input logic [HOURS_W-1:0] h);
        return (h == HOURS_W'(HOURS_MOD - 1)) ? '0 : h + HOURS_W'(1);
    endfunction

    function automatic logic [MINUTES_W-1:0] inc_minutes(input logic [MINUTES_W-1:0] m);
        return (m == MINUTES_W'(MINUTES_MOD - 1)) ? '0 : m + MINUTES_W'(1);
    endfunction

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - synchronizer, debouncer, press detect and optional auto-repeat
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_CYCLES   = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw_i,
    input  logic enable_repeat_i,
    output logic press_o
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RP_W = $clog2(REPEAT_CYCLES + 1);

    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic [RP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic            db_done;
    logic            rise;
    logic            rep_fire;

    // Debounce acceptance and repeat timing; press is flagged in the same cycle the level flips
    always_comb begin
        db_done   = (sync2_q != level_q) && (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1));
        level_d   = db_done ? sync2_q : level_q;
        db_cnt_d  = ((sync2_q == level_q) || db_done) ? '0 : db_cnt_q + DB_W'(1);
        rise      = db_done && sync2_q;
        rep_fire  = enable_repeat_i && level_q && (rep_cnt_q == RP_W'(REPEAT_CYCLES - 1));
        rep_cnt_d = (!enable_repeat_i || !level_q || rep_fire) ? '0 : rep_cnt_q + RP_W'(1);
        press_o   = rise || rep_fire;
    end

    // Synchronizer, debounced level and counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            level_q   <= 1'b0;
            db_cnt_q  <= '0;
            rep_cnt_q <= '0;
        end else begin
            sync1_q   <= btn_raw_i;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            db_cnt_q  <= db_cnt_d;
            rep_cnt_q <= rep_cnt_d;
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - front-panel time setting FSM with hold, load and field blink
module time_set_ctrl
    import time_set_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int BLINK_CYCLES    = 50,
    parameter int REPEAT_CYCLES   = 50,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 btn_mode,
    input  logic                 btn_inc,
    input  logic [HOURS_W-1:0]   hours_cur,
    input  logic [MINUTES_W-1:0] minutes_cur,
    output logic                 hold,
    output logic                 load,
    output logic [HOURS_W-1:0]   hours_set,
    output logic [MINUTES_W-1:0] minutes_set,
    output logic                 blank_hours,
    output logic                 blank_minutes,
    output logic [1:0]           edit_state
);

    localparam int IDLE_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BLINK_W = $clog2(BLINK_CYCLES + 1);

    logic mode_press;
    logic inc_press_raw;
    logic inc_press;

    edit_state_e          state_q, state_d;
    logic [HOURS_W-1:0]   hours_q, hours_d;
    logic [MINUTES_W-1:0] minutes_q, minutes_d;
    logic [IDLE_W-1:0]    idle_q, idle_d;
    logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
    logic                 phase_q, phase_d;
    logic                 hold_q, load_q, blank_h_q, blank_m_q;
    logic                 editing;
    logic                 timed_out;

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_mode_btn (
        .clk             (clk),
        .rst             (rst),
        .btn_raw_i       (btn_mode),
        .enable_repeat_i (1'b0),
        .press_o         (mode_press)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_inc_btn (
        .clk             (clk),
        .rst             (rst),
        .btn_raw_i       (btn_inc),
        .enable_repeat_i (1'b1),
        .press_o         (inc_press_raw)
    );

    // MODE takes priority: a coincident INC press is dropped
    assign inc_press = inc_press_raw && !mode_press;

    // Next-state, edit fields, idle timeout and blink phase
    always_comb begin
        state_d     = state_q;
        hours_d     = hours_q;
        minutes_d   = minutes_q;
        editing     = (state_q == ST_SET_H) || (state_q == ST_SET_M);
        timed_out   = (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1));
        idle_d      = editing ? idle_q + IDLE_W'(1) : '0;
        blink_cnt_d = '0;
        phase_d     = 1'b0;
        if (editing) begin
            if (blink_cnt_q == BLINK_W'(BLINK_CYCLES - 1)) begin
                phase_d = !phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
                phase_d     = phase_q;
            end
        end

        case (state_q)
            ST_RUN: begin
                if (mode_press) begin
                    state_d   = ST_SET_H;
                    hours_d   = clamp_hours(hours_cur);
                    minutes_d = clamp_minutes(minutes_cur);
                    idle_d    = '0;
                end
            end
            ST_SET_H: begin
                if (mode_press) begin
                    state_d     = ST_SET_M;
                    idle_d      = '0;
                    blink_cnt_d = '0;
                    phase_d     = 1'b0;
                end else if (inc_press) begin
                    hours_d     = inc_hours(hours_q);
                    idle_d      = '0;
                    blink_cnt_d = '0;
                    phase_d     = 1'b0;
                end else if (timed_out) begin
                    state_d = ST_RUN;
                    idle_d  = '0;
                end
            end
            ST_SET_M: begin
                if (mode_press) begin
                    state_d = ST_COMMIT;
                    idle_d  = '0;
                end else if (inc_press) begin
                    minutes_d   = inc_minutes(minutes_q);
                    idle_d      = '0;
                    blink_cnt_d = '0;
                    phase_d     = 1'b0;
                end else if (timed_out) begin
                    state_d = ST_RUN;
                    idle_d  = '0;
                end
            end
            ST_COMMIT: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State, edit registers and outputs registered from next state so they align with edit_state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            hours_q     <= '0;
            minutes_q   <= '0;
            idle_q      <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            hold_q      <= 1'b0;
            load_q      <= 1'b0;
            blank_h_q   <= 1'b0;
            blank_m_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hours_q     <= hours_d;
            minutes_q   <= minutes_d;
            idle_q      <= idle_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            hold_q      <= (state_d != ST_RUN);
            load_q      <= (state_d == ST_COMMIT);
            blank_h_q   <= (state_d == ST_SET_H) && phase_d;
            blank_m_q   <= (state_d == ST_SET_M) && phase_d;
        end
    end

    assign hold          = hold_q;
    assign load          = load_q;
    assign hours_set     = hours_q;
    assign minutes_set   = minutes_q;
    assign blank_hours   = blank_h_q;
    assign blank_minutes = blank_m_q;
    assign edit_state    = state_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - self-checking bench for time_set_ctrl
module tb_time_set_ctrl;

    localparam int DEB   = 4;
    localparam int BLINK = 50;
    localparam int REP   = 50;
    localparam int TMO   = 1000;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_mode;
    logic       btn_inc;
    logic [4:0] hours_cur;
    logic [5:0] minutes_cur;
    logic       hold;
    logic       load;
    logic [4:0] hours_set;
    logic [5:0] minutes_set;
    logic       blank_hours;
    logic       blank_minutes;
    logic [1:0] edit_state;

    int total = 0;
    int bad   = 0;
    int load_seen = 0;
    int load_h = 0;
    int load_m = 0;
    int exp_h = 0;
    int exp_m = 0;

    time_set_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .BLINK_CYCLES    (BLINK),
        .REPEAT_CYCLES   (REP),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_mode      (btn_mode),
        .btn_inc       (btn_inc),
        .hours_cur     (hours_cur),
        .minutes_cur   (minutes_cur),
        .hold          (hold),
        .load          (load),
        .hours_set     (hours_set),
        .minutes_set   (minutes_set),
        .blank_hours   (blank_hours),
        .blank_minutes (blank_minutes),
        .edit_state    (edit_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst === 1'b1 && load === 1'b1) begin
            load_seen = load_seen + 1;
            load_h = int'(hours_set);
            load_m = int'(minutes_set);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic int clamp(input int v, input int modv);
        return (v >= modv) ? 0 : v;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One clean short press (well under the auto-repeat interval), then full release
    task automatic press(input bit is_mode);
        if (is_mode) btn_mode = 1'b1;
        else         btn_inc  = 1'b1;
        tick(8);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        tick(8);
    endtask

    task automatic test_reset;
        rst = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
        hours_cur = 5'd0; minutes_cur = 6'd0;
        tick(3);
        total++;
        if ({hold, load, blank_hours, blank_minutes} !== 4'b0) begin
            bad++; $display("FAIL reset_flags: got %b want 0000", {hold, load, blank_hours, blank_minutes});
        end
        total++;
        if (edit_state !== 2'd0) begin
            bad++; $display("FAIL reset_state: got %0d want 0", edit_state);
        end
        total++;
        if ({hours_set, minutes_set} !== 11'd0) begin
            bad++; $display("FAIL reset_fields: got %0d:%0d want 0:0", hours_set, minutes_set);
        end
        rst = 1'b1;
        tick(2);
        for (int i = 0; i < 20; i++) begin
            btn_mode = (i % 2 == 0);
            tick(1);
        end
        btn_mode = 1'b0;
        tick(10);
        total++;
        if (edit_state !== 2'd0 || hold !== 1'b0) begin
            bad++; $display("FAIL bounce_ignored: got state=%0d hold=%0d want 0/0", edit_state, hold);
        end
    endtask

    task automatic test_enter_edit;
        hours_cur = 5'd7; minutes_cur = 6'd30;
        btn_mode = 1'b1;
        tick(DEB + 1);
        total++;
        if (edit_state !== 2'd0) begin
            bad++; $display("FAIL enter_early: got state=%0d want 0", edit_state);
        end
        tick(1);
        total++;
        if (edit_state !== 2'd1 || hold !== 1'b1 || hours_set !== 5'd7 || minutes_set !== 6'd30) begin
            bad++; $display("FAIL enter_edit: got st=%0d hold=%0d %0d:%0d want 1/1 7:30",
                            edit_state, hold, hours_set, minutes_set);
        end
        btn_mode = 1'b0;
        tick(10);
        exp_h = 7; exp_m = 30;
    endtask

    task automatic test_wrap;
        int lb;
        while (exp_h != 23) begin
            press(1'b0);
            exp_h = (exp_h + 1) % 24;
        end
        total++;
        if (int'(hours_set) !== 23) begin
            bad++; $display("FAIL hours_to_23: got %0d want 23", hours_set);
        end
        press(1'b0);
        exp_h = (exp_h + 1) % 24;
        total++;
        if (int'(hours_set) !== exp_h) begin
            bad++; $display("FAIL hours_wrap: got %0d want %0d", hours_set, exp_h);
        end
        press(1'b1);
        total++;
        if (edit_state !== 2'd2 || int'(minutes_set) !== exp_m) begin
            bad++; $display("FAIL to_set_m: got st=%0d m=%0d want 2 %0d", edit_state, minutes_set, exp_m);
        end
        while (exp_m != 59) begin
            press(1'b0);
            exp_m = (exp_m + 1) % 60;
        end
        press(1'b0);
        exp_m = (exp_m + 1) % 60;
        total++;
        if (int'(minutes_set) !== exp_m || int'(hours_set) !== exp_h) begin
            bad++; $display("FAIL minutes_wrap: got %0d:%0d want %0d:%0d", hours_set, minutes_set, exp_h, exp_m);
        end
        lb = load_seen;
        press(1'b1);
        total++;
        if (load_seen !== lb + 1 || load_h !== exp_h || load_m !== exp_m || edit_state !== 2'd0) begin
            bad++; $display("FAIL wrap_commit: got loads=%0d %0d:%0d st=%0d want %0d %0d:%0d 0",
                            load_seen - lb, load_h, load_m, edit_state, 1, exp_h, exp_m);
        end
    endtask

    task automatic test_auto_repeat;
        int held;
        hours_cur = 5'd5; minutes_cur = 6'd10;
        press(1'b1);
        press(1'b1);
        total++;
        if (edit_state !== 2'd2 || minutes_set !== 6'd10) begin
            bad++; $display("FAIL repeat_setup: got st=%0d m=%0d want 2 10", edit_state, minutes_set);
        end
        held = 160;
        btn_inc = 1'b1;
        tick(2 + DEB);
        tick(held);
        btn_inc = 1'b0;
        tick(12);
        exp_m = (10 + 1 + held / REP) % 60;
        total++;
        if (int'(minutes_set) !== exp_m) begin
            bad++; $display("FAIL auto_repeat: got %0d want %0d", minutes_set, exp_m);
        end
        press(1'b1);
    endtask

    task automatic test_full_commit;
        int lb;
        hours_cur = 5'd10; minutes_cur = 6'd3;
        press(1'b1);
        press(1'b0); press(1'b0);
        press(1'b1);
        press(1'b0); press(1'b0);
        lb = load_seen;
        btn_mode = 1'b1;
        tick(DEB + 1);
        total++;
        if (edit_state !== 2'd2 || load !== 1'b0) begin
            bad++; $display("FAIL commit_early: got st=%0d load=%0d want 2/0", edit_state, load);
        end
        tick(1);
        total++;
        if (load !== 1'b1 || hold !== 1'b1 || edit_state !== 2'd3 || hours_set !== 5'd12 || minutes_set !== 6'd5) begin
            bad++; $display("FAIL commit_cycle: got load=%0d hold=%0d st=%0d %0d:%0d want 1/1/3 12:5",
                            load, hold, edit_state, hours_set, minutes_set);
        end
        btn_mode = 1'b0;
        tick(1);
        total++;
        if (load !== 1'b0 || hold !== 1'b0 || edit_state !== 2'd0) begin
            bad++; $display("FAIL after_commit: got load=%0d hold=%0d st=%0d want 0/0/0", load, hold, edit_state);
        end
        tick(10);
        total++;
        if (load_seen !== lb + 1) begin
            bad++; $display("FAIL load_count: got %0d want 1", load_seen - lb);
        end
    endtask

    task automatic test_timeout_blink;
        int lb;
        int blink_err;
        int state_err;
        hours_cur = 5'd15; minutes_cur = 6'd45;
        lb = load_seen;
        btn_mode = 1'b1;
        tick(2 + DEB);
        btn_mode = 1'b0;
        blink_err = 0;
        state_err = 0;
        if (edit_state !== 2'd1 || blank_hours !== 1'b0) state_err++;
        for (int k = 1; k < TMO; k++) begin
            tick(1);
            if (edit_state !== 2'd1) state_err++;
            if (blank_hours !== logic'((k / BLINK) % 2) || blank_minutes !== 1'b0) blink_err++;
        end
        total++;
        if (state_err != 0) begin
            bad++; $display("FAIL timeout_early: got %0d cycles off SET_H want 0", state_err);
        end
        total++;
        if (blink_err != 0) begin
            bad++; $display("FAIL blink_hours: got %0d wrong cycles want 0", blink_err);
        end
        tick(1);
        total++;
        if (edit_state !== 2'd0 || hold !== 1'b0 || blank_hours !== 1'b0) begin
            bad++; $display("FAIL timeout: got st=%0d hold=%0d blank=%0d want 0/0/0", edit_state, hold, blank_hours);
        end
        tick(10);
        total++;
        if (load_seen !== lb) begin
            bad++; $display("FAIL timeout_noload: got %0d loads want 0", load_seen - lb);
        end
    endtask

    task automatic test_simultaneous;
        hours_cur = 5'd20; minutes_cur = 6'd0;
        press(1'b1);
        btn_mode = 1'b1; btn_inc = 1'b1;
        tick(2 + DEB);
        total++;
        if (edit_state !== 2'd2 || hours_set !== 5'd20) begin
            bad++; $display("FAIL mode_wins: got st=%0d h=%0d want 2 20", edit_state, hours_set);
        end
        btn_mode = 1'b0; btn_inc = 1'b0;
        tick(12);
        total++;
        if (edit_state !== 2'd2 || hours_set !== 5'd20 || minutes_set !== 6'd0) begin
            bad++; $display("FAIL inc_dropped: got st=%0d %0d:%0d want 2 20:0", edit_state, hours_set, minutes_set);
        end
    endtask

    task automatic test_reset_mid_edit;
        int lb;
        lb = load_seen;
        tick(3);
        rst = 1'b0;
        #1;
        total++;
        if (edit_state !== 2'd0 || load !== 1'b0 || hold !== 1'b0 || blank_minutes !== 1'b0) begin
            bad++; $display("FAIL reset_mid_edit: got st=%0d load=%0d hold=%0d want 0/0/0", edit_state, load, hold);
        end
        tick(2);
        rst = 1'b1;
        tick(5);
        total++;
        if (load_seen !== lb || edit_state !== 2'd0) begin
            bad++; $display("FAIL reset_noload: got loads=%0d st=%0d want 0 0", load_seen - lb, edit_state);
        end
    endtask

    task automatic test_random_edits;
        int hc, mc, nh, nm, lb;
        for (int it = 0; it < 4; it++) begin
            hc = $urandom_range(0, 31);
            mc = $urandom_range(0, 63);
            nh = $urandom_range(0, 26);
            nm = $urandom_range(0, 62);
            hours_cur = 5'(hc); minutes_cur = 6'(mc);
            exp_h = clamp(hc, 24);
            exp_m = clamp(mc, 60);
            press(1'b1);
            total++;
            if (edit_state !== 2'd1 || int'(hours_set) !== exp_h || int'(minutes_set) !== exp_m) begin
                bad++; $display("FAIL rnd_capture: got st=%0d %0d:%0d want 1 %0d:%0d",
                                edit_state, hours_set, minutes_set, exp_h, exp_m);
            end
            for (int i = 0; i < nh; i++) press(1'b0);
            exp_h = (exp_h + nh) % 24;
            press(1'b1);
            for (int i = 0; i < nm; i++) press(1'b0);
            exp_m = (exp_m + nm) % 60;
            lb = load_seen;
            press(1'b1);
            total++;
            if (load_seen !== lb + 1 || load_h !== exp_h || load_m !== exp_m || hold !== 1'b0) begin
                bad++; $display("FAIL rnd_commit: got loads=%0d %0d:%0d hold=%0d want 1 %0d:%0d 0",
                                load_seen - lb, load_h, load_m, hold, exp_h, exp_m);
            end
        end
    endtask

    initial begin
        test_reset();
        test_enter_edit();
        test_wrap();
        test_auto_repeat();
        test_full_commit();
        test_timeout_blink();
        test_simultaneous();
        test_reset_mid_edit();
        test_random_edits();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
